// File: rtl/pwm_period_meter.sv
// PWM period meter: recovers period, high time and volume code from a square/PWM input.
// Results are registered and announced by a one-cycle new_period strobe.
module pwm_period_meter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_PERIOD  = 16,
  parameter int unsigned TIMEOUT     = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic [3:0]       volume_out,
  output logic             new_period,
  output logic             locked,
  output logic             lost
);

  typedef enum logic {StHunt, StMeasure} state_e;

  state_e                 r_state, w_state_d;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [WIDTH-1:0]       r_cnt, r_h_lat, w_dist;
  logic                   w_s, w_rise, w_fall;
  logic                   w_first, w_accept, w_timeout;

  function automatic int unsigned f_msb(input logic [WIDTH-1:0] x);
    f_msb = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (x[i]) f_msb = i;
    end
  endfunction

  // Inverse of the generator's H = P >> (16 - vol), compared by magnitude only.
  function automatic logic [3:0] f_vol(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] h);
    int unsigned mp, mh, d;
    mp = f_msb(p);
    mh = f_msb(h);
    if (h == '0) begin
      f_vol = 4'd0;
    end else if (mh >= mp) begin
      f_vol = 4'd15;
    end else begin
      d = mp - mh - 1;
      f_vol = (d > 15) ? 4'd0 : 4'(15 - d);
    end
  endfunction

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_dist = (r_cnt == '1) ? r_cnt : r_cnt + WIDTH'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StHunt;
    else       r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StHunt:    if (w_rise) w_state_d = StMeasure;
      StMeasure: if (w_timeout) w_state_d = StHunt;
      default:   w_state_d = StHunt;
    endcase
  end

  // Event decode; an accepted rise pre-empts a coincident timeout.
  always_comb begin
    w_first   = (r_state == StHunt) && w_rise;
    w_accept  = (r_state == StMeasure) && w_rise && (w_dist >= WIDTH'(MIN_PERIOD));
    w_timeout = (r_state == StMeasure) && !w_accept && (r_cnt == WIDTH'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync     <= '0;
      r_s_d      <= 1'b0;
      r_cnt      <= '0;
      r_h_lat    <= '0;
      period_out <= '0;
      high_out   <= '0;
      volume_out <= '0;
      new_period <= 1'b0;
      locked     <= 1'b0;
      lost       <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d      <= w_s;
      new_period <= w_accept;
      lost       <= w_timeout;

      if (w_first || w_accept)  r_cnt <= '0;
      else if (r_cnt != '1)     r_cnt <= r_cnt + WIDTH'(1);

      if (w_first || w_accept)                  r_h_lat <= '0;
      else if ((r_state == StMeasure) && w_fall) r_h_lat <= w_dist;

      if (w_accept) begin
        period_out <= w_dist;
        high_out   <= r_h_lat;
        volume_out <= f_vol(w_dist, r_h_lat);
        locked     <= 1'b1;
      end else if (w_timeout) begin
        locked     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_period_meter.sv
// Bench for pwm_period_meter: event-level model in pin time, delayed by the sync latency,
// compared every cycle, plus literal checks at the end of each directed segment.
module tb_pwm_period_meter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned MINP  = 16;
  localparam int unsigned TMO   = 5000;
  // Drive cycle of a pin change to the cycle the DUT shows its result.
  localparam int LAT = SYNC + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             pwm_in;
  logic [WIDTH-1:0] period_out, high_out;
  logic [3:0]       volume_out;
  logic             new_period, locked, lost;

  pwm_period_meter #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC),
    .MIN_PERIOD (MINP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .period_out(period_out),
    .high_out  (high_out),
    .volume_out(volume_out),
    .new_period(new_period),
    .locked    (locked),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] high;
    logic [3:0]  vol;
    logic        np;
    logic        lk;
    logic        ls;
  } exp_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  exp_t exp_cur;
  exp_t q[$];

  // Model state, in units of drive cycles since the last model reset.
  bit   m_hunt;
  bit   m_prev;
  int   m_k, m_tr, m_h;
  exp_t m_out;

  int seg_idx, seg_strobes, seg_first, seg_lost;

  task automatic chk(input string nm, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, got, want);
    end
  endtask

  function automatic int vol_model(input longint p, input longint h);
    int mp = 0;
    int mh = 0;
    int d;
    longint x;
    if (h == 0) return 0;
    x = p;
    while (x > 1) begin x = x >> 1; mp++; end
    x = h;
    while (x > 1) begin x = x >> 1; mh++; end
    if (mh >= mp) return 15;
    d = mp - mh - 1;
    return (d > 15) ? 0 : 15 - d;
  endfunction

  task automatic model_reset();
    m_hunt = 1'b1;
    m_prev = 1'b0;
    m_k    = 0;
    m_tr   = 0;
    m_h    = 0;
    m_out  = '0;
    q.delete();
    for (int i = 0; i < LAT; i++) q.push_back('0);
  endtask

  task automatic model_step(input bit v);
    bit acc = 1'b0;
    m_out.np = 1'b0;
    m_out.ls = 1'b0;
    if (v && !m_prev) begin
      if (m_hunt) begin
        m_hunt = 1'b0;
        m_tr   = m_k;
        m_h    = 0;
      end else if (m_k - m_tr >= int'(MINP)) begin
        m_out.period = 32'(m_k - m_tr);
        m_out.high   = 32'(m_h);
        m_out.vol    = 4'(vol_model(m_k - m_tr, m_h));
        m_out.np     = 1'b1;
        m_out.lk     = 1'b1;
        m_tr         = m_k;
        m_h          = 0;
        acc          = 1'b1;
      end
    end
    if (!v && m_prev && !m_hunt) m_h = m_k - m_tr;
    if (!m_hunt && !acc && (m_k - m_tr == int'(TMO))) begin
      m_out.ls = 1'b1;
      m_out.lk = 1'b0;
      m_hunt   = 1'b1;
    end
    m_prev = v;
    m_k++;
    q.push_back(m_out);
  endtask

  task automatic seg_begin();
    seg_idx     = 0;
    seg_strobes = 0;
    seg_first   = -1;
    seg_lost    = -1;
  endtask

  task automatic step(input bit v, input bit r);
    @(posedge clk);
    #1;
    if (new_period) begin
      seg_strobes++;
      if (seg_first < 0) seg_first = seg_idx;
    end
    if (lost && seg_lost < 0) seg_lost = seg_idx;
    reset = r;
    if (r) begin
      model_reset();
      exp_cur = '0;
    end else begin
      model_step(v);
      exp_cur = q.pop_front();
    end
    pwm_in = v;
    seg_idx++;
  endtask

  task automatic wave(input int period, input int high, input int n);
    for (int i = 0; i < n; i++) step((i % period) < high, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("period_out", longint'(period_out), longint'(exp_cur.period));
      chk("high_out",   longint'(high_out),   longint'(exp_cur.high));
      chk("volume_out", longint'(volume_out), longint'(exp_cur.vol));
      chk("new_period", longint'(new_period), longint'(exp_cur.np));
      chk("locked",     longint'(locked),     longint'(exp_cur.lk));
      chk("lost",       longint'(lost),       longint'(exp_cur.ls));
    end
  end

  initial begin
    reset   = 1'b1;
    pwm_in  = 1'b0;
    model_reset();
    exp_cur = '0;
    chk_en  = 1'b1;

    // Reset held while the input toggles.
    seg_begin();
    for (int i = 0; i < 10; i++) step((i % 2) == 1, 1'b1);
    chk("t1_period", longint'(period_out), 0);
    chk("t1_locked", longint'(locked), 0);
    chk("t1_strobe", longint'(new_period), 0);

    // 50% duty: first strobe only at the second rise, then every period.
    seg_begin();
    wave(1000, 500, 4000);
    chk("t2_first_strobe", seg_first, 1000 + LAT);
    chk("t2_strobes", seg_strobes, 3);
    chk("t2_period", longint'(period_out), 1000);
    chk("t2_high", longint'(high_out), 500);
    chk("t2_vol", longint'(volume_out), 15);
    chk("t2_locked", longint'(locked), 1);

    // Lower volume codes.
    seg_begin();
    wave(1000, 62, 2000);
    chk("t3_strobes", seg_strobes, 2);
    chk("t3a_high", longint'(high_out), 62);
    chk("t3a_vol", longint'(volume_out), 12);
    seg_begin();
    wave(1000, 1, 2000);
    chk("t3b_high", longint'(high_out), 1);
    chk("t3b_vol", longint'(volume_out), 7);

    // Glitch rise 5 clks after a real rise must be ignored.
    seg_begin();
    for (int i = 0; i < 2000; i++) begin
      int p;
      p = i % 1000;
      step((p < 3) || (p >= 5 && p < 500), 1'b0);
    end
    chk("t4_strobes", seg_strobes, 2);
    chk("t4_period", longint'(period_out), 1000);
    chk("t4_high", longint'(high_out), 500);
    chk("t4_vol", longint'(volume_out), 15);

    // Input stuck low: last accepted rise was 1000 clks before this segment.
    seg_begin();
    for (int i = 0; i < 4100; i++) step(1'b0, 1'b0);
    chk("t5_lost_at", seg_lost, 4000 + LAT);
    chk("t5_locked", longint'(locked), 0);
    chk("t5_period", longint'(period_out), 1000);
    chk("t5_high", longint'(high_out), 500);
    chk("t5_vol", longint'(volume_out), 15);
    seg_begin();
    wave(1000, 500, 3000);
    chk("t5_relock_first", seg_first, 1000 + LAT);
    chk("t5_relock_strobes", seg_strobes, 2);
    chk("t5_relock_locked", longint'(locked), 1);

    // Reset in the middle of a period, then the wave resumes.
    seg_begin();
    wave(1000, 500, 1300);
    step(1'b1, 1'b1);
    #1;
    chk("t6_rst_period", longint'(period_out), 0);
    chk("t6_rst_high", longint'(high_out), 0);
    chk("t6_rst_locked", longint'(locked), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    seg_begin();
    wave(1000, 500, 3000);
    chk("t6_first", seg_first, 1000 + LAT);
    chk("t6_period", longint'(period_out), 1000);
    chk("t6_high", longint'(high_out), 500);
    chk("t6_locked", longint'(locked), 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
